// File: rtl/v850_prefetch_queue.sv
// V850 instruction prefetch queue: fetches FETCH_HW-halfword beats into a circular
// buffer and exposes a four-halfword decode window with variable-length pop.
module v850_prefetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                FETCH_HW = 2,
  parameter int                DEPTH_HW = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    mem_req_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [16*FETCH_HW-1:0]  mem_rdata_i,
  input  logic                    redirect_i,
  input  logic [ADDR_W-1:0]       redirect_pc_i,
  output logic [63:0]             inst_o,
  output logic [$clog2(DEPTH_HW):0] inst_cnt_o,
  output logic [ADDR_W-1:0]       head_pc_o,
  input  logic                    pop_i,
  input  logic [2:0]              pop_len_i,
  output logic                    pop_err_o
);

  localparam int PTR_W  = $clog2(DEPTH_HW);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SKIP_W = (FETCH_HW > 1) ? $clog2(FETCH_HW) : 1;
  localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(2 * FETCH_HW);

  function automatic logic [ADDR_W-1:0] beat_align(input logic [ADDR_W-1:0] pc);
    return pc & ~(BEAT_BYTES - ADDR_W'(1));
  endfunction

  function automatic logic [SKIP_W-1:0] skip_of(input logic [ADDR_W-1:0] pc);
    return SKIP_W'((pc >> 1) & ADDR_W'(FETCH_HW - 1));
  endfunction

  logic [15:0]       buf_q [DEPTH_HW];
  logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d, fill_num;
  logic [ADDR_W-1:0] fa_q, fa_d, head_pc_q, head_pc_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic              req_q, req_d, outst_q, outst_d, stale_q, stale_d;
  logic              pop_err_q, pop_err_d;
  logic              grant, fill, pop_ok;
  logic [PTR_W-1:0]  wr_idx [FETCH_HW];
  logic              wr_en  [FETCH_HW];

  // NOTE: every variable assigned in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    count_q  = wr_ptr_q - rd_ptr_q;
    grant    = req_q & mem_gnt_i;
    fill     = mem_rvalid_i & outst_q & ~stale_q & ~redirect_i;
    fill_num = fill ? (CNT_W'(FETCH_HW) - CNT_W'(skip_q)) : '0;
    pop_ok   = pop_i && (pop_len_i != 3'd0) && (pop_len_i <= 3'd4) &&
               (int'(pop_len_i) <= int'(count_q));

    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    fa_d      = fa_q;
    head_pc_d = head_pc_q;
    skip_d    = skip_q;
    outst_d   = outst_q;
    stale_d   = stale_q;
    pop_err_d = 1'b0;

    if (mem_rvalid_i && outst_q) begin
      outst_d = 1'b0;
      stale_d = 1'b0;
    end
    if (grant) begin
      outst_d = 1'b1;
      fa_d    = fa_q + BEAT_BYTES;
    end

    if (redirect_i) begin
      // Whatever is still in flight after this cycle belongs to the old stream.
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      head_pc_d = redirect_pc_i;
      fa_d      = beat_align(redirect_pc_i);
      skip_d    = skip_of(redirect_pc_i);
      stale_d   = outst_d;
    end else begin
      if (fill) begin
        wr_ptr_d = wr_ptr_q + fill_num;
        skip_d   = '0;
      end
      if (pop_ok) begin
        rd_ptr_d  = rd_ptr_q + CNT_W'(pop_len_i);
        head_pc_d = head_pc_q + ADDR_W'({pop_len_i, 1'b0});
      end else begin
        pop_err_d = pop_i;
      end
    end

    count_d = wr_ptr_d - rd_ptr_d;
    if (redirect_i)   req_d = ~outst_d;
    else if (req_q)   req_d = ~mem_gnt_i;
    else              req_d = ~outst_d && (int'(count_d) + FETCH_HW <= DEPTH_HW);
  end

  always_comb begin
    for (int j = 0; j < FETCH_HW; j++) begin
      wr_en[j]  = fill && (j >= int'(skip_q));
      wr_idx[j] = PTR_W'(wr_ptr_q + CNT_W'(j) - CNT_W'(skip_q));
    end
  end

  // NOTE: the buffer has no reset; occupancy comes from the pointers, so stale
  // contents are never visible and the array can map onto plain storage.
  always_ff @(posedge clk) begin
    for (int j = 0; j < FETCH_HW; j++) begin
      if (wr_en[j]) buf_q[wr_idx[j]] <= mem_rdata_i[16*j +: 16];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      fa_q      <= beat_align(RESET_PC);
      head_pc_q <= RESET_PC;
      skip_q    <= skip_of(RESET_PC);
      req_q     <= 1'b0;
      outst_q   <= 1'b0;
      stale_q   <= 1'b0;
      pop_err_q <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      fa_q      <= fa_d;
      head_pc_q <= head_pc_d;
      skip_q    <= skip_d;
      req_q     <= req_d;
      outst_q   <= outst_d;
      stale_q   <= stale_d;
      pop_err_q <= pop_err_d;
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      inst_o[16*k +: 16] = (k < int'(count_q)) ? buf_q[PTR_W'(rd_ptr_q + CNT_W'(k))] : 16'h0;
    end
  end

  assign mem_req_o  = req_q;
  assign mem_addr_o = fa_q;
  assign inst_cnt_o = count_q;
  assign head_pc_o  = head_pc_q;
  assign pop_err_o  = pop_err_q;

endmodule

// File: tb/tb_v850_prefetch_queue.sv
// Randomised bench for v850_prefetch_queue: a memory responder plus a model that
// tracks the queue as "count halfwords starting at head pc" of a fixed memory image.
module tb_v850_prefetch_queue;

  localparam int          F      = 2;
  localparam int          D      = 8;
  localparam logic [31:0] RST_PC = 32'h100;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_req_o, mem_gnt_i, mem_rvalid_i;
  logic [31:0]   mem_addr_o, redirect_pc_i, head_pc_o;
  logic [16*F-1:0] mem_rdata_i;
  logic          redirect_i, pop_i, pop_err_o;
  logic [63:0]   inst_o;
  logic [3:0]    inst_cnt_o;
  logic [2:0]    pop_len_i;

  v850_prefetch_queue #(.ADDR_W(32), .FETCH_HW(F), .DEPTH_HW(D), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .inst_o(inst_o), .inst_cnt_o(inst_cnt_o), .head_pc_o(head_pc_o),
    .pop_i(pop_i), .pop_len_i(pop_len_i), .pop_err_o(pop_err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state
  logic [31:0] pc_m = RST_PC;
  int          count_m = 0;
  bit          pend = 0, stale_m = 0, exp_err = 0;
  logic [31:0] pend_addr = '0;
  int          lat_cnt = 0, lat_sel = 0, gnt_prob = 100, n_grants = 0;
  logic [31:0] gaddr_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] mem_hw(input logic [31:0] a);
    return a[16:1] ^ a[31:16] ^ 16'hC3A5;
  endfunction

  function automatic logic [16*F-1:0] beat(input logic [31:0] a);
    logic [16*F-1:0] d;
    for (int j = 0; j < F; j++) d[16*j +: 16] = mem_hw(a + 32'(2*j));
    return d;
  endfunction

  function automatic logic [31:0] ga(input int k);
    return (gaddr_q.size() > k) ? gaddr_q[k] : 32'hDEAD_BEEF;
  endfunction

  // One clock: drive inputs at negedge, advance the model, check after the edge.
  task automatic tick(input bit do_pop = 0, input int len = 0,
                      input bit do_redir = 0, input logic [31:0] rpc = '0);
    logic        req_s;
    logic [31:0] addr_s, fill_pc;
    logic [63:0] exp_inst;
    bit          g, rv;
    int          cnt_old;
    req_s   = mem_req_o;
    addr_s  = mem_addr_o;
    g       = req_s && !pend && ($urandom_range(99) < gnt_prob);
    rv      = pend && (lat_cnt == 0);
    mem_gnt_i     = g;
    mem_rvalid_i  = rv;
    mem_rdata_i   = rv ? beat(pend_addr) : (16*F)'($urandom);
    pop_i         = do_pop;
    pop_len_i     = 3'(len);
    redirect_i    = do_redir;
    redirect_pc_i = rpc;

    cnt_old = count_m;
    fill_pc = pc_m + 32'(2*count_m);
    exp_err = 0;
    if (g) check("fetch_addr", addr_s, fill_pc & ~32'(2*F-1));
    if (rv) begin
      pend = 0;
      if (!stale_m && !do_redir) count_m += int'((pend_addr + 32'(2*F) - fill_pc) >> 1);
      stale_m = 0;
    end else if (pend && lat_cnt > 0) begin
      lat_cnt--;
    end
    if (do_redir) begin
      if (pend) stale_m = 1;
      pc_m    = rpc;
      count_m = 0;
    end else if (do_pop) begin
      if (len >= 1 && len <= 4 && len <= cnt_old) begin
        pc_m    = pc_m + 32'(2*len);
        count_m -= len;
      end else begin
        exp_err = 1;
      end
    end
    if (g) begin
      pend      = 1;
      stale_m   = do_redir;
      pend_addr = addr_s;
      lat_cnt   = (lat_sel < 0) ? $urandom_range(0, 2) : lat_sel;
      n_grants++;
      if (!do_redir) gaddr_q.push_back(addr_s);
    end

    @(posedge clk);
    @(negedge clk);
    exp_inst = '0;
    for (int k = 0; k < 4; k++)
      if (k < count_m) exp_inst[16*k +: 16] = mem_hw(pc_m + 32'(2*k));
    check("cnt", inst_cnt_o, count_m);
    check("head_pc", head_pc_o, pc_m);
    check("inst", inst_o, exp_inst);
    check("pop_err", pop_err_o, exp_err);
    check("one_outstanding", mem_req_o && pend, 0);
    check("req_room", mem_req_o && (count_m + F > D), 0);
  endtask

  initial begin
    rst = 1'b1;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    redirect_i = 0; redirect_pc_i = '0; pop_i = 0; pop_len_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", mem_req_o, 0);
    check("rst_addr", mem_addr_o, RST_PC);
    check("rst_cnt", inst_cnt_o, 0);
    check("rst_inst", inst_o, 0);
    check("rst_head", head_pc_o, RST_PC);
    check("rst_err", pop_err_o, 0);
    rst = 1'b0;

    // Fill from reset until the queue stalls full
    tick();
    check("req_after_rst", mem_req_o, 1);
    check("addr_after_rst", mem_addr_o, RST_PC);
    for (int i = 0; i < 40 && inst_cnt_o != 4'(D); i++) tick();
    check("fill_to_full", inst_cnt_o, D);
    repeat (4) tick();
    check("stall_req", mem_req_o, 0);
    check("stall_cnt", inst_cnt_o, D);
    check("grant0", ga(0), 32'h100);
    check("grant1", ga(1), 32'h104);
    check("grant2", ga(2), 32'h108);
    check("head_hw0", inst_o[15:0], mem_hw(32'h100));

    // Unaligned redirect: latency and skipped first halfword
    begin
      int exp_seq [4] = '{0, 1, 1, 3};
      tick(.do_redir(1), .rpc(32'h20A));
      check("redir_req", mem_req_o, 1);
      check("redir_addr", mem_addr_o, 32'h208);
      check("redir_head", head_pc_o, 32'h20A);
      for (int k = 0; k < 4; k++) begin
        tick();
        check("redir_cnt_seq", inst_cnt_o, exp_seq[k]);
      end
    end

    // Pop of 3 in the same cycle as a 2-halfword fill
    tick(.do_redir(1), .rpc(32'h300));
    for (int i = 0; i < 40 && !(count_m == 6 && pend && lat_cnt == 0); i++) tick();
    check("popfill_setup", inst_cnt_o, 6);
    tick(.do_pop(1), .len(3));
    check("popfill_cnt", inst_cnt_o, 5);
    check("popfill_head", head_pc_o, 32'h306);

    // Redirect while a granted beat is still in flight
    lat_sel = 2;
    for (int i = 0; i < 20 && !(pend && !stale_m && lat_cnt == 2); i++) tick();
    check("stale_setup", pend && !stale_m, 1);
    gaddr_q.delete();
    tick(.do_redir(1), .rpc(32'h400));
    lat_sel = 0;
    for (int i = 0; i < 20 && gaddr_q.size() == 0; i++) tick();
    check("stale_next_addr", ga(0), 32'h400);
    for (int i = 0; i < 20 && inst_cnt_o == 0; i++) tick();
    check("stale_hw0", inst_o[15:0], mem_hw(32'h400));

    // Illegal pops with two halfwords queued
    tick(.do_redir(1), .rpc(32'h500));
    for (int i = 0; i < 10 && count_m != 2; i++) tick();
    gnt_prob = 0;
    tick(.do_pop(1), .len(4));
    check("err_len4", pop_err_o, 1);
    check("err_len4_cnt", inst_cnt_o, 2);
    tick(.do_pop(1), .len(0));
    check("err_len0", pop_err_o, 1);
    tick();
    check("err_clear", pop_err_o, 0);
    check("err_cnt", inst_cnt_o, 2);
    check("err_head", head_pc_o, 32'h500);

    // Random traffic: variable grant/data latency, pops, redirects incl. address wrap
    gnt_prob = 70;
    lat_sel  = -1;
    n_grants = 0;
    for (int c = 0; c < 3000; c++) begin
      bit          p, r;
      int          len;
      logic [31:0] rpc;
      p   = ($urandom_range(99) < 40);
      len = ($urandom_range(9) < 8) ? $urandom_range(1, 4) : $urandom_range(0, 7);
      r   = ($urandom_range(99) < 3);
      rpc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + 32'(2*$urandom_range(0, 7))
                                     : 32'h600 + 32'(2*$urandom_range(0, 255));
      tick(.do_pop(p), .len(len), .do_redir(r), .rpc(rpc));
    end
    check("liveness", n_grants > 300, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
